// File: rtl/riscv_id_pipe.sv
// RV decode stage: one-deep output register with valid/ready on both sides,
// a per-register busy scoreboard for RAW hazards and writeback forwarding.
module riscv_id_pipe #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int RW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    output logic [RW-1:0]   rs1_addr,
    output logic [RW-1:0]   rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            wb_valid,
    input  logic [RW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RW-1:0]   rd,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [XLEN-1:0] c,
    output logic [2:0]      funct3,
    output logic            alt,
    output logic [2:0]      kind,
    output logic            exception
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;

    localparam logic [2:0] KIND_ALU   = 3'd0;
    localparam logic [2:0] KIND_LOAD  = 3'd1;
    localparam logic [2:0] KIND_STORE = 3'd2;
    localparam logic [2:0] KIND_JAL   = 3'd3;
    localparam logic [2:0] KIND_NONE  = 3'd7;

    function automatic logic field_bad(input logic [4:0] f);
        return 32'(f) >= 32'(NREGS);
    endfunction

    logic [4:0] rd_field, rs1_field, rs2_field;
    logic is_op, is_opimm, is_load, is_store, is_lui, is_auipc, is_jal;
    logic known, use_rs1, use_rs2, has_rd, illegal;
    logic hit1, hit2, stall, accept;
    logic [XLEN-1:0] rs1v, rs2v, imm_i, imm_s, imm_u, imm_j;
    logic [NREGS-1:1] busy, busy_next;
    logic [NREGS-1:0] busy_all;

    logic [RW-1:0]   d_rd;
    logic [XLEN-1:0] d_a, d_b, d_c;
    logic [2:0]      d_funct3, d_kind;
    logic            d_alt, d_exception;

    assign rd_field  = instruction[11:7];
    assign rs1_field = instruction[19:15];
    assign rs2_field = instruction[24:20];
    assign rs1_addr  = rs1_field[RW-1:0];
    assign rs2_addr  = rs2_field[RW-1:0];

    assign is_op    = instruction[6:0] == OPC_OP;
    assign is_opimm = instruction[6:0] == OPC_OPIMM;
    assign is_load  = instruction[6:0] == OPC_LOAD;
    assign is_store = instruction[6:0] == OPC_STORE;
    assign is_lui   = instruction[6:0] == OPC_LUI;
    assign is_auipc = instruction[6:0] == OPC_AUIPC;
    assign is_jal   = instruction[6:0] == OPC_JAL;

    // Opcode compares already cover instr[1:0]==2'b11; only fields the format uses are range-checked.
    assign known   = is_op | is_opimm | is_load | is_store | is_lui | is_auipc | is_jal;
    assign use_rs1 = is_op | is_opimm | is_load | is_store;
    assign use_rs2 = is_op | is_store;
    assign has_rd  = known & ~is_store;
    assign illegal = ~known
                   | (use_rs1 & field_bad(rs1_field))
                   | (use_rs2 & field_bad(rs2_field))
                   | (has_rd & field_bad(rd_field));

    assign imm_i = XLEN'($signed(instruction[31:20]));
    assign imm_s = XLEN'($signed({instruction[31:25], instruction[11:7]}));
    assign imm_u = XLEN'($signed({instruction[31:12], 12'h000}));
    assign imm_j = XLEN'($signed({instruction[31], instruction[19:12], instruction[20],
                                  instruction[30:21], 1'b0}));

    assign hit1 = wb_valid && (wb_rd == rs1_addr);
    assign hit2 = wb_valid && (wb_rd == rs2_addr);
    assign rs1v = (rs1_addr == '0) ? '0 : (hit1 ? wb_data : rs1_data);
    assign rs2v = (rs2_addr == '0) ? '0 : (hit2 ? wb_data : rs2_data);

    // x0 has no busy bit; a writeback landing this cycle releases the hazard.
    assign busy_all = {busy, 1'b0};
    assign stall    = ~illegal
                    & ((use_rs1 & busy_all[rs1_addr] & ~hit1)
                     | (use_rs2 & busy_all[rs2_addr] & ~hit2));
    assign in_ready = (~out_valid | out_ready) & ~stall;
    assign accept   = in_valid & in_ready;

    always_comb begin
        d_rd        = '0;
        d_a         = '0;
        d_b         = '0;
        d_c         = '0;
        d_funct3    = 3'd0;
        d_alt       = 1'b0;
        d_kind      = KIND_NONE;
        d_exception = 1'b0;
        if (illegal) begin
            d_exception = 1'b1;
        end else begin
            d_kind = KIND_ALU;
            if (has_rd) d_rd = rd_field[RW-1:0];
            if (use_rs1) begin
                d_a      = rs1v;
                d_funct3 = instruction[14:12];
            end
            if (is_op || (is_opimm && instruction[13:12] == 2'b01))
                d_alt = instruction[30];
            if (is_opimm || is_load) d_b = imm_i;
            if (is_op) d_b = rs2v;
            if (is_load) d_kind = KIND_LOAD;
            if (is_store) begin
                d_b    = imm_s;
                d_c    = rs2v;
                d_kind = KIND_STORE;
            end
            if (is_lui) d_b = imm_u;
            if (is_auipc) begin
                d_a = pc;
                d_b = imm_u;
            end
            if (is_jal) begin
                d_a    = pc;
                d_b    = XLEN'(4);
                d_c    = pc + imm_j;
                d_kind = KIND_JAL;
            end
        end
    end

    // A set from this cycle's accept takes priority over a clear from writeback.
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_busy
        assign busy_next[gi] = (accept && d_rd == RW'(gi))
                             | (busy[gi] & ~(wb_valid && wb_rd == RW'(gi)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            rd        <= '0;
            a         <= '0;
            b         <= '0;
            c         <= '0;
            funct3    <= 3'd0;
            alt       <= 1'b0;
            kind      <= KIND_NONE;
            exception <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            rd        <= d_rd;
            a         <= d_a;
            b         <= d_b;
            c         <= d_c;
            funct3    <= d_funct3;
            alt       <= d_alt;
            kind      <= d_kind;
            exception <= d_exception;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_id_pipe.sv
// Randomized scoreboard bench for riscv_id_pipe (XLEN=32, NREGS=32): a stimulus
// process predicts each accepted op from ISA rules, a monitor checks it on output.
module tb_riscv_id_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instruction, pc;
    logic [4:0]  rs1_addr, rs2_addr, wb_rd, rd;
    logic [31:0] rs1_data, rs2_data, wb_data, a, b, c;
    logic        wb_valid, alt, exception;
    logic [2:0]  funct3, kind;

    riscv_id_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc(pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .rd(rd), .a(a), .b(b), .c(c),
        .funct3(funct3), .alt(alt), .kind(kind), .exception(exception)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [2:0]  f3;
        logic        alt;
        logic [2:0]  kind;
        logic        exc;
    } op_t;

    op_t         expq[$];
    int          wbq[$];
    logic [31:0] rf[32];
    bit          busy_m[32];
    bit          exp_ov;
    int          nvec = 0;
    int          nerr = 0;

    // Register file lives in the bench; the DUT reads it through its address ports.
    always_comb begin
        rs1_data = rf[rs1_addr];
        rs2_data = rf[rs2_addr];
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] srcv(input logic [4:0] r, input bit wv,
                                         input logic [4:0] wr, input logic [31:0] wd);
        if (r == 0) return 32'h0;
        if (wv && wr == r) return wd;
        return rf[r];
    endfunction

    function automatic bit uses1(input logic [6:0] o);
        return o == 7'b0110011 || o == 7'b0010011 || o == 7'b0000011 || o == 7'b0100011;
    endfunction

    function automatic bit uses2(input logic [6:0] o);
        return o == 7'b0110011 || o == 7'b0100011;
    endfunction

    function automatic op_t ref_dec(input logic [31:0] ins, input logic [31:0] p, input bit wv,
                                    input logic [4:0] wr, input logic [31:0] wd);
        op_t e;
        logic [31:0] v1, v2, ii, is_, iu, ij;
        v1  = srcv(ins[19:15], wv, wr, wd);
        v2  = srcv(ins[24:20], wv, wr, wd);
        ii  = {{20{ins[31]}}, ins[31:20]};
        is_ = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        iu  = {ins[31:12], 12'h000};
        ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        e = '0;
        case (ins[6:0])
            7'b0010011: begin
                e.rd = ins[11:7]; e.a = v1; e.b = ii; e.f3 = ins[14:12];
                e.alt = (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) ? ins[30] : 1'b0;
            end
            7'b0110011: begin
                e.rd = ins[11:7]; e.a = v1; e.b = v2; e.f3 = ins[14:12]; e.alt = ins[30];
            end
            7'b0000011: begin
                e.rd = ins[11:7]; e.a = v1; e.b = ii; e.f3 = ins[14:12]; e.kind = 3'd1;
            end
            7'b0100011: begin
                e.a = v1; e.b = is_; e.c = v2; e.f3 = ins[14:12]; e.kind = 3'd2;
            end
            7'b0110111: begin e.rd = ins[11:7]; e.b = iu; end
            7'b0010111: begin e.rd = ins[11:7]; e.a = p; e.b = iu; end
            7'b1101111: begin
                e.rd = ins[11:7]; e.a = p; e.b = 32'd4; e.c = p + ij; e.kind = 3'd3;
            end
            default: begin e.exc = 1'b1; e.kind = 3'd7; end
        endcase
        return e;
    endfunction

    // One clock of stimulus: drive at negedge, predict in_ready, commit model after the edge.
    task automatic cycle(input bit iv, input logic [31:0] ins, input logic [31:0] p, input bit ordy,
                         input bit wv, input logic [4:0] wr, input logic [31:0] wd);
        op_t e;
        bit stall_m, rdy_m, acc;
        logic [4:0] r1, r2;
        @(negedge clk);
        in_valid = iv; instruction = ins; pc = p; out_ready = ordy;
        wb_valid = wv; wb_rd = wr; wb_data = wd;
        #1;
        r1 = ins[19:15];
        r2 = ins[24:20];
        e = ref_dec(ins, p, wv, wr, wd);
        stall_m = !e.exc && ((uses1(ins[6:0]) && busy_m[r1] && !(wv && wr == r1))
                          || (uses2(ins[6:0]) && busy_m[r2] && !(wv && wr == r2)));
        rdy_m = (!exp_ov || ordy) && !stall_m;
        chk("in_ready", in_ready, rdy_m);
        acc = iv && rdy_m;
        @(posedge clk);
        #1;
        if (wv && wr != 0) begin
            busy_m[wr] = 1'b0;
            rf[wr] = wd;
        end
        if (acc) begin
            expq.push_back(e);
            if (e.rd != 0) begin
                busy_m[e.rd] = 1'b1;
                wbq.push_back(int'(e.rd));
            end
            exp_ov = 1'b1;
        end else if (ordy) begin
            exp_ov = 1'b0;
        end
    endtask

    function automatic logic [31:0] addi(input int rdn, input int rs, input int imm);
        logic [11:0] i12 = 12'(imm);
        return {i12, 5'(rs), 3'b000, 5'(rdn), 7'b0010011};
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [31:0] r = $urandom();
        int k = $urandom_range(0, 10);
        r[11:7]  = 5'($urandom_range(0, 7));
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        case (k)
            0, 1:    r[6:0] = 7'b0010011;
            2, 3:    r[6:0] = 7'b0110011;
            4:       r[6:0] = 7'b0000011;
            5:       r[6:0] = 7'b0100011;
            6:       r[6:0] = 7'b0110111;
            7:       r[6:0] = 7'b0010111;
            8:       r[6:0] = 7'b1101111;
            9:       r[6:0] = 7'b1110011;
            default: r[1:0] = 2'($urandom_range(0, 2));
        endcase
        return r;
    endfunction

    // Monitor: compares the head of the queue whenever an op is presented.
    initial begin
        op_t g, e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) continue;
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("out_valid_unexpected", out_valid, 1'b0);
                end else begin
                    e = expq[0];
                    g.rd = rd; g.a = a; g.b = b; g.c = c;
                    g.f3 = e.exc ? 3'd0 : funct3;
                    g.alt = e.exc ? 1'b0 : alt;
                    g.kind = kind; g.exc = exception;
                    chk("op", g, e);
                    if (out_ready) begin
                        $display("op rd=%0d a=%h b=%h c=%h f3=%0d kind=%0d exc=%0b",
                                 rd, a, b, c, funct3, kind, exception);
                        void'(expq.pop_front());
                    end
                end
            end else if (expq.size() != 0) begin
                chk("out_valid_missing", out_valid, 1'b1);
            end
        end
    end

    initial begin
        logic [20:0] j;
        bit wv;
        logic [4:0] wr;
        in_valid = 0; instruction = 0; pc = 0; out_ready = 1;
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        for (int i = 0; i < 32; i++) begin
            rf[i] = $urandom();
            busy_m[i] = 1'b0;
        end
        rf[0] = 32'hBAD0BAD0;
        rf[1] = 32'h00000100;
        rf[2] = 32'hDEADBEEF;
        exp_ov = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_rd", rd, 5'd0);
        chk("rst_abc", {a, b, c}, 96'h0);
        chk("rst_f3_alt", {funct3, alt}, 4'h0);
        chk("rst_kind", kind, 3'd7);
        chk("rst_exc", exception, 1'b0);
        rst = 1'b0;

        // addi x5,x0,42; x0 must read as zero even though rf[0] is not
        cycle(1, addi(5, 0, 42), 32'h0, 1, 0, 0, 0);
        chk("addi_rd", rd, 5'd5);
        chk("addi_ab", {a, b}, {32'd0, 32'd42});
        chk("addi_kind", {kind, exception, out_valid}, {3'd0, 1'b0, 1'b1});

        // addi x6,x5,1 stalls on busy x5 until its writeback, then forwards it
        repeat (3) cycle(1, addi(6, 5, 1), 32'h4, 1, 0, 0, 0);
        cycle(1, addi(6, 5, 1), 32'h4, 1, 1, 5'd5, 32'd42);
        chk("fwd_ab", {a, b}, {32'd42, 32'd1});
        chk("fwd_rd", rd, 5'd6);
        cycle(0, 32'h0, 32'h0, 1, 1, 5'd6, 32'd43);

        // backpressure: held op stays stable, next op follows in order
        cycle(1, addi(7, 0, 7), 32'h8, 0, 0, 0, 0);
        repeat (3) cycle(1, addi(8, 0, 8), 32'hC, 0, 0, 0, 0);
        chk("hold_rd_b", {rd, b}, {5'd7, 32'd7});
        cycle(1, addi(8, 0, 8), 32'hC, 1, 0, 0, 0);
        chk("release_rd", rd, 5'd8);

        // sw x2,-4(x1)
        cycle(1, {7'h7F, 5'd2, 5'd1, 3'b010, 5'h1C, 7'b0100011}, 32'h10, 1, 0, 0, 0);
        chk("sw_abc", {a, b, c}, {32'h100, 32'hFFFFFFFC, 32'hDEADBEEF});
        chk("sw_rd_kind", {rd, kind}, {5'd0, 3'd2});

        // lui x3,0xFFFFF
        cycle(1, {20'hFFFFF, 5'd3, 7'b0110111}, 32'h14, 1, 0, 0, 0);
        chk("lui_ab", {a, b}, {32'h0, 32'hFFFFF000});

        // jal x10,-8 at pc 0x80
        j = 21'h1FFFF8;
        cycle(1, {j[20], j[10:1], j[11], j[19:12], 5'd10, 7'b1101111}, 32'h80, 1, 0, 0, 0);
        chk("jal_abc", {a, b, c}, {32'h80, 32'd4, 32'h78});
        chk("jal_rd_kind", {rd, kind}, {5'd10, 3'd3});

        // all-zero word is illegal
        cycle(1, 32'h0, 32'h84, 1, 0, 0, 0);
        chk("illegal_exc_kind", {exception, kind, rd}, {1'b1, 3'd7, 5'd0});
        chk("illegal_abc", {a, b, c}, 96'h0);

        // randomized traffic with writebacks returned from a pending queue
        for (int n = 0; n < 600; n++) begin
            wv = 0;
            wr = 0;
            if (wbq.size() != 0 && $urandom_range(0, 1) == 1) begin
                wv = 1;
                wr = 5'(wbq.pop_front());
            end
            cycle($urandom_range(0, 3) != 0, rand_ins(), {$urandom_range(0, 4095), 2'b00},
                  $urandom_range(0, 3) != 0, wv, wr, $urandom());
        end

        // asynchronous reset drops a held op and clears the scoreboard
        cycle(0, 32'h0, 32'h0, 1, 0, 0, 0);
        cycle(1, addi(5, 0, 5), 32'h0, 0, 0, 0, 0);
        cycle(1, addi(6, 5, 1), 32'h4, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_kind", {kind, rd}, {3'd7, 5'd0});
        rst = 1'b0;
        expq.delete();
        wbq.delete();
        for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
        exp_ov = 1'b0;
        cycle(1, addi(6, 5, 1), 32'h4, 1, 0, 0, 0);
        chk("post_rst_rd", rd, 5'd6);
        cycle(0, 32'h0, 32'h0, 1, 0, 0, 0);
        cycle(0, 32'h0, 32'h0, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/riscv_id_pipe.md
# riscv_id_pipe

Parametrised, pipelined RV instruction-decode stage with valid/ready handshakes on both sides, a register scoreboard for RAW hazards, and writeback forwarding. Sits between fetch and execute. Covers OP, OP-IMM, LOAD, STORE, LUI, AUIPC and JAL. Produces registered ALU operands `a`/`b`, store data `c`, destination `rd` and decode control, with one-cycle latency.

## Interface
- `XLEN`, 32: datapath width, 32 or 64; immediates sign-extend to XLEN.
- `NREGS`, 32: architectural register count, 16 or 32; `RW = $clog2(NREGS)`.
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  fetch presents `instruction`/`pc`.
- `in_ready`  out  1  stage accepts this cycle.
- `instruction`  in  32  raw instruction word.
- `pc`  in  XLEN  instruction address.
- `rs1_addr`, `rs2_addr`  out  RW  combinational register-file read addresses (instr[19:15], instr[24:20], truncated).
- `rs1_data`, `rs2_data`  in  XLEN  register-file read data, same cycle.
- `wb_valid`  in  1  writeback retiring.
- `wb_rd`  in  RW  writeback destination.
- `wb_data`  in  XLEN  writeback value.
- `out_valid`  out  1  decoded op valid.
- `out_ready`  in  1  execute accepts.
- `rd`  out  RW  destination; 0 if none.
- `a`, `b`  out  XLEN  ALU operands.
- `c`  out  XLEN  store data; 0 otherwise.
- `funct3`  out  3  instr[14:12]; 0 for LUI/AUIPC/JAL.
- `alt`  out  1  instr[30] for OP and for OP-IMM shifts (funct3 001/101); else 0.
- `kind`  out  3  0 ALU, 1 LOAD, 2 STORE, 3 JAL, 7 none.
- `exception`  out  1  illegal instruction.

## Operation
- Operand map (rs1 is `rs1v`, rs2 is `rs2v` after forwarding):
  - OP-IMM: a=rs1v, b=imm_i.
  - OP: a=rs1v, b=rs2v.
  - LOAD: a=rs1v, b=imm_i.
  - STORE: a=rs1v, b=imm_s, c=rs2v, rd=0.
  - LUI: a=0, b=imm_u.
  - AUIPC: a=pc, b=imm_u.
  - JAL: a=pc, b=4, c=pc+imm_j.
- Forwarding: `rs1v` = `wb_data` when `wb_valid` && `wb_rd==rs1_addr` && `rs1_addr!=0`; otherwise `rs1_data`. Same rule for rs2. Register x0 always reads 0.
- Illegal instruction: instr[1:0]!=2'b11, an unsupported opcode, or a register field >= NREGS.
  - Output: exception=1, kind=7, rd=a=b=c=0.
  - Never stalls; scoreboard unchanged.
- Scoreboard: `busy[NREGS-1:1]`.
  - Sets `busy[rd]` on accept when rd!=0 and the op is legal.
  - `wb_valid` clears `busy[wb_rd]`.
  - Same register set and cleared in one cycle: set wins.
- Hazard: `stall` = a used source (OP/STORE: rs1,rs2; OP-IMM/LOAD: rs1; LUI/AUIPC/JAL: none) with busy=1 that is not cleared by this cycle's writeback.
- `in_ready = (~out_valid | out_ready) & ~stall`.
- Accept = `in_valid & in_ready`.
  - Output register loads.
  - `out_valid` <= 1.
- If no accept and `out_ready`: `out_valid` <= 0.
- While `out_valid & ~out_ready`: all outputs hold.

## Timing
- Reset: `out_valid`=0, `rd`=`a`=`b`=`c`=0, `funct3`=0, `alt`=0, `kind`=7, `exception`=0, busy=0.
- Asserting `rst` mid-operation drops any held op immediately.
- Latency: accept at edge N; result visible after edge N; `out_valid` high in cycle N+1.
- Throughput: one op per cycle when no stall and `out_ready`=1.
- Back-to-back dependent ALU op: stalls until the producer's `wb_valid`. It accepts in the writeback cycle using forwarded data.
- `in_ready` depends combinationally on `out_ready`, `instruction`, `wb_*`.
- `in_ready` never depends on `in_valid`.

## Test plan
- Reset, XLEN=32: instruction={12'd42,5'd0,3'b000,5'd5,7'b0010011}, in_valid=1 -> next cycle out_valid=1, rd=5, a=0, b=42, funct3=0, kind=0, exception=0. busy[5]=1.
- Dependency stall: then `addi t1,t0,1` -> in_ready=0 until wb_valid with wb_rd=5, wb_data=42. That cycle it accepts; next cycle a=42, b=1, rd=6.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0. On release the next op issues in order, with no loss or duplication.
- Immediates: `sw x2,-4(x1)` with rs1_data=0x100, rs2_data=0xDEADBEEF -> a=0x100, b=0xFFFFFFFC, c=0xDEADBEEF, rd=0, kind=2. `lui x3,0xFFFFF` at XLEN=64 -> b=0xFFFFFFFF_FFFFF000.
- JAL at pc=0x80, imm_j=-8 -> a=0x80, b=4, c=0x78, kind=3, rd as encoded.
- Illegal: instruction=0 -> exception=1, kind=7, busy unchanged.
  - NREGS=16 with rd=17 -> exception=1.
  - rst asserted while out_valid=1 -> out_valid=0 asynchronously.
